// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the ALU, its
// decoders and benches.
package alu_pkg;
    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
endpackage

// File: rtl/alu_if.sv
// Operand/opcode bus into the ALU and its registered result/flag back out.
interface alu_if #(
    parameter int WIDTH = alu_pkg::DEF_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       operation;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (output A, B, operation, input result, cout);
    modport slave  (input A, B, operation, output result, cout);
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: eight unsigned ops plus a carry/borrow/shift flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_d_o,
    output logic             cout_d_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit holds the carry out, or the borrow for subtraction.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_d_o = '0;
        cout_d_o   = 1'b0;
        case (op_i)
            OP_ADD: {cout_d_o, result_d_o} = sum;
            OP_SUB: {cout_d_o, result_d_o} = diff;
            OP_AND: result_d_o = a_i & b_i;
            OP_OR:  result_d_o = a_i | b_i;
            OP_XOR: result_d_o = a_i ^ b_i;
            OP_NOT: result_d_o = ~a_i;
            OP_SHL: begin
                result_d_o = {a_i[WIDTH-2:0], 1'b0};
                cout_d_o   = a_i[WIDTH-1];
            end
            OP_SHR: begin
                result_d_o = {1'b0, a_i[WIDTH-1:1]};
                cout_d_o   = a_i[0];
            end
            default: begin
                result_d_o = '0;
                cout_d_o   = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/alu.sv
// Registered ALU: combinational core followed by one output register stage,
// accepting a new operation every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);
    logic [WIDTH-1:0] result_d, result_q;
    logic             cout_d, cout_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a_i        (bus.A),
        .b_i        (bus.B),
        .op_i       (bus.operation),
        .result_d_o (result_d),
        .cout_d_o   (cout_d)
    );

    // Reset wins over whatever operation is presented on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign bus.result = result_q;
    assign bus.cout   = cout_q;
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expected results, monitor checks
// the registered outputs one edge later.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference computed from the opcode definitions with plain integer math.
    function automatic void model(input int a, input int b, input int op,
                                  output logic [W-1:0] r, output logic c);
        int v;
        int cf;
        v  = 0;
        cf = 0;
        case (op)
            0: begin v = (a + b) % M; cf = ((a + b) >= M) ? 1 : 0; end
            1: begin v = (a - b + M) % M; cf = (a < b) ? 1 : 0; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            5: v = (M - 1) - a;
            6: begin v = (a * 2) % M; cf = (a >= M / 2) ? 1 : 0; end
            default: begin v = a / 2; cf = a % 2; end
        endcase
        r = v[W-1:0];
        c = cf[0];
    endfunction

    task automatic drive_exp(input logic r, input int a, input int b, input int op,
                             input logic [W-1:0] er, input logic ec, input string nm);
        exp_t e;
        @(negedge clk);
        rst           = r;
        bus.A         = a[W-1:0];
        bus.B         = b[W-1:0];
        bus.operation = op[2:0];
        e.res  = er;
        e.c    = ec;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input int a, input int b, input int op, input string nm);
        logic [W-1:0] er;
        logic         ec;
        model(a, b, op, er, ec);
        if (r) begin
            er = '0;
            ec = 1'b0;
        end
        drive_exp(r, a, b, op, er, ec, nm);
    endtask

    // Monitor: every edge with a pending expectation is checked just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (bus.result !== e.res || bus.cout !== e.c) begin
                    n_fail++;
                    $display("FAIL %s: got result=%b cout=%b, want result=%b cout=%b",
                             e.name, bus.result, bus.cout, e.res, e.c);
                end
            end
        end
    end

    initial begin
        int budget;
        rst           = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.operation = '0;

        drive_exp(1'b1, 4'b0110, 4'b1111, 0, 4'b0000, 1'b0, "reset0");
        drive_exp(1'b1, 4'b1111, 4'b1111, 6, 4'b0000, 1'b0, "reset1");

        // Reference operands stepped through every opcode, then wrap to ADD.
        drive_exp(1'b0, 4'b1011, 4'b1000, 0, 4'b0011, 1'b1, "add");
        drive_exp(1'b0, 4'b1011, 4'b1000, 1, 4'b0011, 1'b0, "sub");
        drive_exp(1'b0, 4'b1011, 4'b1000, 2, 4'b1000, 1'b0, "and");
        drive_exp(1'b0, 4'b1011, 4'b1000, 3, 4'b1011, 1'b0, "or");
        drive_exp(1'b0, 4'b1011, 4'b1000, 4, 4'b0011, 1'b0, "xor");
        drive_exp(1'b0, 4'b1011, 4'b1000, 5, 4'b0100, 1'b0, "not");
        drive_exp(1'b0, 4'b1011, 4'b1000, 6, 4'b0110, 1'b1, "shl");
        drive_exp(1'b0, 4'b1011, 4'b1000, 7, 4'b0101, 1'b1, "shr");
        drive_exp(1'b0, 4'b1011, 4'b1000, 0, 4'b0011, 1'b1, "add_again");
        drive_exp(1'b0, 4'b1011, 4'b1000, 0, 4'b0011, 1'b1, "hold");

        drive_exp(1'b0, 4'b0011, 4'b1000, 1, 4'b1011, 1'b1, "sub_borrow");
        drive_exp(1'b0, 4'b0100, 4'b0000, 7, 4'b0010, 1'b0, "shr_lsb0");
        drive_exp(1'b0, 4'b1111, 4'b1111, 0, 4'b1110, 1'b1, "add_max");
        drive_exp(1'b0, 4'b0000, 4'b0000, 1, 4'b0000, 1'b0, "sub_zero");
        drive_exp(1'b0, 4'b0000, 4'b0001, 1, 4'b1111, 1'b1, "sub_wrap");

        // Reset asserted mid-stream, then released onto a fresh operation.
        drive_exp(1'b0, 4'b1111, 4'b0001, 0, 4'b0000, 1'b1, "pre_rst");
        drive_exp(1'b1, 4'b1111, 4'b1111, 3, 4'b0000, 1'b0, "mid_rst");
        drive_exp(1'b0, 4'b0101, 4'b0011, 2, 4'b0001, 1'b0, "post_rst");

        for (int op = 0; op < 8; op++)
            for (int a = 0; a < M; a++)
                for (int b = 0; b < M; b++)
                    drive(1'b0, a, b, op, "exhaustive");

        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 15) == 0), $urandom_range(0, M - 1),
                  $urandom_range(0, M - 1), $urandom_range(0, 7), "random");

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
